// File: rtl/ahb_arb_pkg.sv
`default_nettype none
// ============================================================================
// ahb_arb_pkg : shared HTRANS encodings and arbitration mode constants
// Revision    : 1.0
// ============================================================================
package ahb_arb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
   function automatic logic htrans_active(input logic [1:0] t);
      return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_arb_picker.sv
`default_nettype none
// ============================================================================
// ahb_arb_picker : first requester at or after ptr_i (cyclic), combinational
// Revision       : 1.0
// ============================================================================
module ahb_arb_picker #(
   parameter int NM = 2,
   parameter int IW = 1
) (
   input  logic [NM-1:0] req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [NM-1:0] gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);

   always_comb begin
      int          j;
      logic [IW-1:0] j_idx;
      logic        found;
      j     = 0;
      j_idx = '0;
      found = 1'b0;
      gnt_o = '0;
      idx_o = '0;
      for (int k = 0; k < NM; k++) begin
         j = int'(ptr_i) + k;
         if (j >= NM) begin
            j = j - NM;
         end
         j_idx = IW'(j);
         if (!found && req_i[j_idx]) begin
            found        = 1'b1;
            idx_o        = j_idx;
            gnt_o[j_idx] = 1'b1;
         end
      end
      vld_o = found;
   end

endmodule
`default_nettype wire

// File: rtl/ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// ahb_master_arbiter : NM AHB-lite masters onto one bus, one slot per master,
//                      every transfer re-issued as a single NONSEQ
// Revision           : 1.0
// ============================================================================
module ahb_master_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int NM   = 2,
   parameter int MODE = 1,
   parameter int AW   = 32
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic [NM*AW-1:0] HADDR_M,
   input  logic [NM*2-1:0]  HTRANS_M,
   input  logic [NM-1:0]    HWRITE_M,
   input  logic [NM*3-1:0]  HSIZE_M,
   input  logic [NM*32-1:0] HWDATA_M,
   output logic [NM-1:0]    HREADYOUT_M,
   output logic [31:0]      HRDATA_M,
   output logic [AW-1:0]    HADDR,
   output logic [1:0]       HTRANS,
   output logic             HWRITE,
   output logic [2:0]       HSIZE,
   output logic [31:0]      HWDATA,
   input  logic             HREADY,
   input  logic [31:0]      HRDATA,
   output logic [2:0]       HMASTER
);

   localparam int IW = $clog2(NM);

   logic [NM-1:0] valid_q, valid_d;
   logic [NM-1:0] issued_q, issued_d;
   logic [AW-1:0] addr_q [NM];
   logic [AW-1:0] addr_d [NM];
   logic [NM-1:0] write_q, write_d;
   logic [2:0]    size_q [NM];
   logic [2:0]    size_d [NM];
   logic          a_valid_q, a_valid_d;
   logic [IW-1:0] owner_a_q, owner_a_d;
   logic          d_valid_q, d_valid_d;
   logic [IW-1:0] owner_d_q, owner_d_d;
   logic [IW-1:0] last_q, last_d;

   logic [AW-1:0] w_addr_m  [NM];
   logic [2:0]    w_size_m  [NM];
   logic [31:0]   w_wdata_m [NM];
   logic [NM-1:0] w_capture;
   logic [NM-1:0] w_req;
   logic [IW-1:0] w_ptr;
   logic [NM-1:0] w_pick_gnt;
   logic [IW-1:0] w_pick_idx;
   logic          w_pick_vld;

   generate
      for (genvar i = 0; i < NM; i++) begin : g_master
         assign w_addr_m[i]  = HADDR_M[i*AW +: AW];
         assign w_size_m[i]  = HSIZE_M[i*3 +: 3];
         assign w_wdata_m[i] = HWDATA_M[i*32 +: 32];
         // A pending slot stalls its master until its own bus data phase.
         assign HREADYOUT_M[i] = !valid_q[i] ? 1'b1 :
                                 (d_valid_q && (owner_d_q == IW'(i))) ? HREADY : 1'b0;
         assign w_capture[i] = HREADYOUT_M[i] && htrans_active(HTRANS_M[2*i +: 2]);
      end
   endgenerate

   assign w_req = valid_q & ~issued_q;
   assign w_ptr = (MODE == MODE_RR) ?
                  ((last_q == IW'(NM-1)) ? '0 : last_q + 1'b1) : '0;

   ahb_arb_picker #(
      .NM (NM),
      .IW (IW)
   ) u_picker (
      .req_i (w_req),
      .ptr_i (w_ptr),
      .gnt_o (w_pick_gnt),
      .idx_o (w_pick_idx),
      .vld_o (w_pick_vld)
   );

   always_comb begin
      valid_d   = valid_q;
      issued_d  = issued_q;
      addr_d    = addr_q;
      write_d   = write_q;
      size_d    = size_q;
      a_valid_d = a_valid_q;
      owner_a_d = owner_a_q;
      d_valid_d = d_valid_q;
      owner_d_d = owner_d_q;
      last_d    = last_q;
      if (HREADY) begin
         if (d_valid_q) begin
            valid_d[owner_d_q] = 1'b0;
         end
         d_valid_d = a_valid_q;
         owner_d_d = owner_a_q;
         a_valid_d = w_pick_vld;
         if (w_pick_vld) begin
            owner_a_d = w_pick_idx;
            issued_d  = issued_q | w_pick_gnt;
            last_d    = w_pick_idx;
         end
      end
      // Capture last so a master completing this edge can be refilled at once.
      for (int i = 0; i < NM; i++) begin
         if (w_capture[i]) begin
            valid_d[i]  = 1'b1;
            issued_d[i] = 1'b0;
            addr_d[i]   = w_addr_m[i];
            write_d[i]  = HWRITE_M[i];
            size_d[i]   = w_size_m[i];
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         valid_q   <= '0;
         issued_q  <= '0;
         addr_q    <= '{default: '0};
         write_q   <= '0;
         size_q    <= '{default: '0};
         a_valid_q <= 1'b0;
         owner_a_q <= '0;
         d_valid_q <= 1'b0;
         owner_d_q <= '0;
         last_q    <= IW'(NM-1);
      end else begin
         valid_q   <= valid_d;
         issued_q  <= issued_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         size_q    <= size_d;
         a_valid_q <= a_valid_d;
         owner_a_q <= owner_a_d;
         d_valid_q <= d_valid_d;
         owner_d_q <= owner_d_d;
         last_q    <= last_d;
      end
   end

   assign HTRANS   = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR    = a_valid_q ? addr_q[owner_a_q] : '0;
   assign HWRITE   = a_valid_q ? write_q[owner_a_q] : 1'b0;
   assign HSIZE    = a_valid_q ? size_q[owner_a_q] : 3'b000;
   assign HMASTER  = a_valid_q ? 3'(owner_a_q) : 3'b000;
   assign HWDATA   = w_wdata_m[owner_d_q];
   assign HRDATA_M = HRDATA;

endmodule
`default_nettype wire
